// File: rtl/mem_inc.sv
// Shared memory-stage types: decoded access parameters, size/op encodings,
// the access-unit state enum and lane helpers.
package mem_inc;

    typedef struct packed {
        logic       op;             // 1 = read, 0 = write
        logic [1:0] access_size;
        logic       read_unsigned;
    } mem_params_t;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    localparam logic [1:0] ACCESS_BYTE = 2'b00;
    localparam logic [1:0] ACCESS_HALF = 2'b01;
    localparam logic [1:0] ACCESS_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } mem_state_t;

    // The reserved size encoding is reported as a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            ACCESS_BYTE: is_misaligned = 1'b0;
            ACCESS_HALF: is_misaligned = off[0];
            ACCESS_WORD: is_misaligned = |off;
            default:     is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] wstrb_for(input logic [1:0] size, input logic [1:0] off);
        case (size)
            ACCESS_BYTE: wstrb_for = 4'b0001 << off;
            ACCESS_HALF: wstrb_for = 4'b0011 << off;
            default:     wstrb_for = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_for(input logic [1:0] size, input logic [31:0] data);
        case (size)
            ACCESS_BYTE: wdata_for = {4{data[7:0]}};
            ACCESS_HALF: wdata_for = {2{data[15:0]}};
            default:     wdata_for = data;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/half/word from a bus read word and extends it
// for writeback.
module mem_load_align
    import mem_inc::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (size)
            ACCESS_BYTE: load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                                 : {{24{shifted[7]}}, shifted[7:0]};
            ACCESS_HALF: load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                                 : {{16{shifted[15]}}, shifted[15:0]};
            default:     load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: one load or store per request over a req/ack
// word bus, with misalignment and bus-timeout faults.
module mem_access_unit
    import mem_inc::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  mem_params_t       mem_params,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              out_valid,
    output logic [31:0]       load_data,
    output logic              fault_misaligned,
    output logic              fault_timeout,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    mem_state_t        state_q, state_d;
    mem_params_t       params_q, params_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       load_q, load_d;
    logic              fmis_q, fmis_d;
    logic              fto_q, fto_d;
    logic [31:0]       align_data;

    mem_load_align u_align (
        .rdata       (bus_rdata),
        .offset      (addr_q[1:0]),
        .size        (params_q.access_size),
        .is_unsigned (params_q.read_unsigned),
        .load_data   (align_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            params_q <= '0;
            addr_q   <= '0;
            wstrb_q  <= '0;
            wdata_q  <= '0;
            count_q  <= '0;
            load_q   <= '0;
            fmis_q   <= 1'b0;
            fto_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            params_q <= params_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            count_q  <= count_d;
            load_q   <= load_d;
            fmis_q   <= fmis_d;
            fto_q    <= fto_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        params_d = params_q;
        addr_d   = addr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        count_d  = count_q;
        load_d   = load_q;
        fmis_d   = fmis_q;
        fto_d    = fto_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    params_d = mem_params;
                    addr_d   = addr;
                    // Strobes and lane data are prepared once so the bus sees stable values.
                    wstrb_d  = (mem_params.op == MEM_WRITE) ? wstrb_for(mem_params.access_size, addr[1:0]) : 4'b0000;
                    wdata_d  = (mem_params.op == MEM_WRITE) ? wdata_for(mem_params.access_size, store_data) : 32'h0;
                    count_d  = '0;
                    load_d   = 32'h0;
                    fto_d    = 1'b0;
                    fmis_d   = is_misaligned(mem_params.access_size, addr[1:0]);
                    state_d  = fmis_d ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                if (bus_ack) begin
                    load_d  = (params_q.op == MEM_READ) ? align_data : 32'h0;
                    state_d = ST_RESP;
                end else if (TIMEOUT_CYCLES != 0 && count_q == CNT_LAST) begin
                    fto_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (count_q != '1) begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // in_ready is held low while reset is asserted.
    assign in_ready         = reset_n && (state_q == ST_IDLE);
    assign bus_req          = (state_q == ST_BUS);
    assign bus_we           = bus_req && (params_q.op == MEM_WRITE);
    assign bus_addr         = bus_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus_wstrb        = bus_we ? wstrb_q : 4'b0000;
    assign bus_wdata        = bus_we ? wdata_q : 32'h0;
    assign out_valid        = (state_q == ST_RESP);
    assign load_data        = out_valid ? load_q : 32'h0;
    assign fault_misaligned = out_valid && fmis_q;
    assign fault_timeout    = out_valid && fto_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// transactions compared against a byte-lane reference model.
module tb_mem_access_unit;
    import mem_inc::*;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    mem_params_t       mem_params = '0;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       store_data = '0;
    logic              out_valid;
    logic [31:0]       load_data;
    logic              fault_misaligned;
    logic              fault_timeout;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_wstrb;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata = '0;
    logic              bus_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .mem_params       (mem_params),
        .addr             (addr),
        .store_data       (store_data),
        .out_valid        (out_valid),
        .load_data        (load_data),
        .fault_misaligned (fault_misaligned),
        .fault_timeout    (fault_timeout),
        .bus_req          (bus_req),
        .bus_we           (bus_we),
        .bus_addr         (bus_addr),
        .bus_wstrb        (bus_wstrb),
        .bus_wdata        (bus_wdata),
        .bus_rdata        (bus_rdata),
        .bus_ack          (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ack_dly: ack in the (ack_dly+1)-th bus_req cycle; negative means never ack.
    task automatic run_txn(input logic op, input logic [1:0] size, input logic uns,
                           input logic [31:0] a, input logic [31:0] sd,
                           input int ack_dly, input logic [31:0] rd);
        logic        mis, tmo;
        int          nbytes, lat, k, req_cycles;
        logic [31:0] exp_load, exp_wdata, v;
        logic [3:0]  exp_strb;
        bit          done;

        nbytes = (size == ACCESS_BYTE) ? 1 : (size == ACCESS_HALF) ? 2 : 4;
        mis = (size == 2'b11) || (size == ACCESS_HALF && a[0]) ||
              (size == ACCESS_WORD && a[1:0] != 2'b00);
        tmo = !mis && (ack_dly < 0 || ack_dly >= TIMEOUT);
        lat = mis ? 1 : (tmo ? TIMEOUT + 1 : ack_dly + 2);

        exp_strb  = 4'b0000;
        exp_wdata = 32'h0;
        for (int i = 0; i < nbytes; i++) exp_strb[(int'(a[1:0]) + i) % 4] = 1'b1;
        for (int j = 0; j < 4; j++) exp_wdata[8*j +: 8] = sd[8*(j % nbytes) +: 8];

        v = rd >> (8 * int'(a[1:0]));
        if (nbytes == 1) begin
            v = v & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (nbytes == 2) begin
            v = v & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end
        exp_load = (mis || tmo || op == MEM_WRITE) ? 32'h0 : v;

        @(negedge clk);
        check_val("in_ready_idle", {31'h0, in_ready}, 32'h1);
        check_val("out_valid_idle", {31'h0, out_valid}, 32'h0);
        in_valid   = 1'b1;
        mem_params = '{op: op, access_size: size, read_unsigned: uns};
        addr       = a;
        store_data = sd;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        mem_params = mem_params_t'($urandom);
        addr       = $urandom;
        store_data = $urandom;

        k = 1;
        req_cycles = 0;
        done = 1'b0;
        while (!done && k <= 40) begin
            bus_ack   = (ack_dly >= 0) && (k - 1 == ack_dly);
            bus_rdata = bus_ack ? rd : $urandom;
            @(negedge clk);
            if (out_valid) begin
                check_val("latency", k, lat);
                check_val("bus_req_at_resp", {31'h0, bus_req}, 32'h0);
                check_val("load_data", load_data, exp_load);
                check_val("fault_misaligned", {31'h0, fault_misaligned}, {31'h0, mis});
                check_val("fault_timeout", {31'h0, fault_timeout}, {31'h0, tmo});
                check_val("in_ready_resp", {31'h0, in_ready}, 32'h0);
                done = 1'b1;
            end else begin
                check_val("in_ready_busy", {31'h0, in_ready}, 32'h0);
                if (bus_req) begin
                    req_cycles++;
                    check_val("bus_addr", bus_addr, {a[31:2], 2'b00});
                    check_val("bus_we", {31'h0, bus_we}, {31'h0, op == MEM_WRITE});
                    check_val("bus_wstrb", {28'h0, bus_wstrb}, (op == MEM_WRITE) ? {28'h0, exp_strb} : 32'h0);
                    if (op == MEM_WRITE) check_val("bus_wdata", bus_wdata, exp_wdata);
                end
                @(posedge clk);
                #1;
                bus_ack = 1'b0;
                k++;
            end
        end
        bus_ack = 1'b0;
        if (!done) check_val("out_valid_timeout", 32'h0, 32'h1);
        check_val("bus_req_cycles", req_cycles, mis ? 0 : lat - 1);
        $display("txn op=%s size=%0d uns=%0d addr=%h sd=%h ack_dly=%0d lat=%0d load=%h mis=%0d tmo=%0d",
                 (op == MEM_READ) ? "RD" : "WR", size, uns, a, sd, ack_dly, k, load_data,
                 fault_misaligned, fault_timeout);
    endtask

    initial begin
        int r, dly;

        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", {31'h0, in_ready}, 32'h0);
        check_val("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check_val("rst_bus_req", {31'h0, bus_req}, 32'h0);
        check_val("rst_load_data", load_data, 32'h0);
        reset_n = 1'b1;
        #1;
        check_val("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

        // Directed cases.
        run_txn(MEM_READ,  ACCESS_BYTE, 1'b0, 32'h0000_1003, 32'h0, 1, 32'h8012_3456);
        run_txn(MEM_READ,  ACCESS_HALF, 1'b1, 32'h0000_2002, 32'h0, 0, 32'hBEEF_1234);
        run_txn(MEM_WRITE, ACCESS_HALF, 1'b0, 32'h0000_3002, 32'h0000_ABCD, 3, 32'h0);
        run_txn(MEM_READ,  ACCESS_WORD, 1'b0, 32'h0000_4001, 32'h0, 0, 32'h1111_2222);
        run_txn(MEM_READ,  2'b11,       1'b0, 32'h0000_0000, 32'h0, -1, 32'h0);
        run_txn(MEM_READ,  ACCESS_WORD, 1'b0, 32'h0000_5000, 32'h0, -1, 32'h0);
        run_txn(MEM_READ,  ACCESS_WORD, 1'b1, 32'h0000_5004, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D);
        run_txn(MEM_WRITE, ACCESS_BYTE, 1'b0, 32'h0000_7001, 32'h1234_56A5, 2, 32'h0);

        // Spurious ack while idle must be ignored.
        @(negedge clk);
        bus_ack = 1'b1;
        @(negedge clk);
        check_val("idle_ack_out_valid", {31'h0, out_valid}, 32'h0);
        check_val("idle_ack_in_ready", {31'h0, in_ready}, 32'h1);
        bus_ack = 1'b0;

        // Reset in the middle of a bus access.
        @(negedge clk);
        in_valid   = 1'b1;
        mem_params = '{op: MEM_READ, access_size: ACCESS_WORD, read_unsigned: 1'b0};
        addr       = 32'h0000_8000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("pre_rst_bus_req", {31'h0, bus_req}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_bus_req", {31'h0, bus_req}, 32'h0);
        check_val("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_val("rel_rst_in_ready", {31'h0, in_ready}, 32'h1);
        check_val("rel_rst_out_valid", {31'h0, out_valid}, 32'h0);
        $display("txn reset during BUS handled");
        run_txn(MEM_WRITE, ACCESS_WORD, 1'b0, 32'h0000_9000, 32'hDEAD_BEEF, 1, 32'h0);

        // Randomized transactions.
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            dly = (r == 0) ? -1 : (r == 1) ? TIMEOUT - 1 : (r == 2) ? TIMEOUT : $urandom_range(0, 4);
            run_txn(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
                    dly, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
